// File: rtl/q_timing_queue.sv
// q_timing_queue
// Timed issue queue. Each accepted instruction is stored together with the
// current timing label; while running, the head entry is released on the
// cycle the free-running timer reaches its label (or immediately, flagged
// late, if the label is already behind the timer).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   q_start / q_stop    run control pulses (stop wins; stop flushes FIFO)
//   q_inst_valid/q_inst instruction push; q_inst_ready = FIFO not full
//   q_time_write/_sel   label update: absolute (sel=0) or relative (sel=1)
//   q_time_reg          label source, low TW bits used
//   issue_valid/_inst/_time  one-cycle registered issue strobe and payload
//   q_empty             FIFO empty
//   overflow_err        sticky: a push was dropped because the FIFO was full
//   late_err            sticky: an entry issued after its label
module q_timing_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          q_start,
  input  logic          q_stop,
  input  logic          q_inst_valid,
  input  logic [63:0]   q_inst,
  output logic          q_inst_ready,
  input  logic          q_time_write,
  input  logic          q_time_sel,
  input  logic [63:0]   q_time_reg,
  output logic          issue_valid,
  output logic [63:0]   issue_inst,
  output logic [TW-1:0] issue_time,
  output logic          q_empty,
  output logic          overflow_err,
  output logic          late_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] label_q, label_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          issue_valid_q, issue_valid_d;
  logic [63:0]   issue_inst_q, issue_inst_d;
  logic [TW-1:0] issue_time_q, issue_time_d;
  logic          ovf_q, ovf_d;
  logic          late_q, late_d;

  logic [63:0]   mem_inst_q  [DEPTH];
  logic [TW-1:0] mem_label_q [DEPTH];

  logic          start_eff;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic          is_late;
  logic [TW-1:0] label_src;
  logic [TW-1:0] head_label;
  logic [TW-1:0] diff;

  generate
    if (TW < 64) begin : g_unused_hi
      logic unused_time_hi;
      assign unused_time_hi = ^q_time_reg[63:TW];
    end
  endgenerate

  assign label_src  = q_time_reg[TW-1:0];
  assign start_eff  = q_start & ~q_stop;
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign head_label = mem_label_q[rd_ptr_q];
  // Signed distance from timer to head label; a set MSB means the label
  // is already behind the timer (modulo wrap).
  assign diff       = head_label - timer_q;

  // A stop flushes the FIFO, so a same-cycle push is silently discarded.
  assign push    = q_inst_valid & ~full & ~q_stop;
  assign drop    = q_inst_valid &  full & ~q_stop;
  assign pop     = (state_q == ST_RUN) & ~empty & ~q_stop &
                   ((diff == '0) | diff[TW-1]);
  assign is_late = pop & diff[TW-1];

  always_comb begin
    state_d = state_q;
    if (q_stop) begin
      state_d = ST_IDLE;
    end else if (q_start) begin
      state_d = ST_RUN;
    end

    if (q_stop || q_start || state_q == ST_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    label_d = label_q;
    if (q_time_write) begin
      label_d = q_time_sel ? (label_q + label_src) : label_src;
    end

    if (q_stop) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    issue_valid_d = pop;
    issue_inst_d  = pop ? mem_inst_q[rd_ptr_q] : issue_inst_q;
    issue_time_d  = pop ? head_label           : issue_time_q;

    ovf_d  = start_eff ? 1'b0 : ovf_q;
    late_d = start_eff ? 1'b0 : late_q;
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (is_late) begin
      late_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      label_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      issue_time_q  <= '0;
      ovf_q         <= 1'b0;
      late_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      label_q       <= label_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      issue_time_q  <= issue_time_d;
      ovf_q         <= ovf_d;
      late_q        <= late_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  // The stored label is the post-update value when a label write coincides.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q]  <= q_inst;
      mem_label_q[wr_ptr_q] <= label_d;
    end
  end

  assign q_inst_ready = ~full;
  assign q_empty      = empty;
  assign issue_valid  = issue_valid_q;
  assign issue_inst   = issue_inst_q;
  assign issue_time   = issue_time_q;
  assign overflow_err = ovf_q;
  assign late_err     = late_q;

endmodule

// File: tb/tb_q_timing_queue.sv
// Directed bench for q_timing_queue (DEPTH=16, TW=8 so timer wrap is reachable).
// Timer origin: after the q_start edge N the timer reads k after edge N+k, and
// an entry with label L is popped at edge N+L+1, so issue_valid is seen with
// (cyc - t0) == L+1.
module tb_q_timing_queue;

  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          q_start = 1'b0;
  logic          q_stop = 1'b0;
  logic          q_inst_valid = 1'b0;
  logic [63:0]   q_inst = '0;
  logic          q_inst_ready;
  logic          q_time_write = 1'b0;
  logic          q_time_sel = 1'b0;
  logic [63:0]   q_time_reg = '0;
  logic          issue_valid;
  logic [63:0]   issue_inst;
  logic [TW-1:0] issue_time;
  logic          q_empty;
  logic          overflow_err;
  logic          late_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit got;

  q_timing_queue #(.DEPTH(16), .TW(TW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .q_start      (q_start),
    .q_stop       (q_stop),
    .q_inst_valid (q_inst_valid),
    .q_inst       (q_inst),
    .q_inst_ready (q_inst_ready),
    .q_time_write (q_time_write),
    .q_time_sel   (q_time_sel),
    .q_time_reg   (q_time_reg),
    .issue_valid  (issue_valid),
    .issue_inst   (issue_inst),
    .issue_time   (issue_time),
    .q_empty      (q_empty),
    .overflow_err (overflow_err),
    .late_err     (late_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] inst, input logic wr, input logic sel,
                      input logic [63:0] lab);
    q_inst_valid = 1'b1;
    q_inst       = inst;
    q_time_write = wr;
    q_time_sel   = sel;
    q_time_reg   = lab;
    tick();
    q_inst_valid = 1'b0;
    q_time_write = 1'b0;
    q_time_sel   = 1'b0;
  endtask

  task automatic pulse_start();
    q_start = 1'b1;
    tick();
    q_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_stop();
    q_stop = 1'b1;
    tick();
    q_stop = 1'b0;
  endtask

  task automatic wait_issue(input int maxc, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (issue_valid === 1'b1) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, q_inst_ready, 1);
    chk({tag, "_ivalid"}, issue_valid, 0);
    chk({tag, "_iinst"}, issue_inst, 0);
    chk({tag, "_itime"}, issue_time, 0);
    chk({tag, "_empty"}, q_empty, 1);
    chk({tag, "_ovf"}, overflow_err, 0);
    chk({tag, "_late"}, late_err, 0);
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    chk_reset_vals("rst");
    rst = 1'b1;
    tick();

    // Absolute labels: 5 and 9
    push(64'hA, 1, 0, 5);
    push(64'hB, 1, 0, 9);
    pulse_start();
    wait_issue(20, got);
    chk("abs_a_found", got, 1);
    chk("abs_a_cyc", cyc - t0, 6);
    chk("abs_a_inst", issue_inst, 64'hA);
    chk("abs_a_time", issue_time, 5);
    wait_issue(20, got);
    chk("abs_b_found", got, 1);
    chk("abs_b_cyc", cyc - t0, 10);
    chk("abs_b_inst", issue_inst, 64'hB);
    chk("abs_b_time", issue_time, 9);
    chk("abs_empty", q_empty, 1);
    chk("abs_late", late_err, 0);
    chk("abs_ovf", overflow_err, 0);
    tick();
    chk("abs_strobe_drop", issue_valid, 0);
    chk("abs_inst_hold", issue_inst, 64'hB);
    chk("abs_time_hold", issue_time, 9);
    pulse_stop();

    // Relative labels: 10, +3 -> 13, +0 -> 13 (issues at 14, late)
    push(64'hA2, 1, 0, 10);
    push(64'hB2, 1, 1, 3);
    push(64'hC2, 1, 1, 0);
    pulse_start();
    wait_issue(30, got);
    chk("rel_a_found", got, 1);
    chk("rel_a_cyc", cyc - t0, 11);
    chk("rel_a_time", issue_time, 10);
    wait_issue(30, got);
    chk("rel_b_found", got, 1);
    chk("rel_b_cyc", cyc - t0, 14);
    chk("rel_b_inst", issue_inst, 64'hB2);
    chk("rel_b_time", issue_time, 13);
    chk("rel_b_late", late_err, 0);
    wait_issue(30, got);
    chk("rel_c_found", got, 1);
    chk("rel_c_cyc", cyc - t0, 15);
    chk("rel_c_inst", issue_inst, 64'hC2);
    chk("rel_c_time", issue_time, 13);
    chk("rel_c_late", late_err, 1);
    pulse_stop();
    chk("stop_keeps_late", late_err, 1);

    // Full / overflow in IDLE
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("ovf_ready_at15", q_inst_ready, 1);
      push(64'h100 + 64'(i), 1, 0, 64'(20 + 2 * i));
    end
    chk("ovf_ready_full", q_inst_ready, 0);
    chk("ovf_not_empty", q_empty, 0);
    push(64'h999, 0, 0, 0);
    chk("ovf_flag", overflow_err, 1);
    pulse_start();
    chk("ovf_cleared", overflow_err, 0);
    chk("late_cleared", late_err, 0);
    for (int i = 0; i < 16; i++) begin
      wait_issue(60, got);
      chk("ovf_found", got, 1);
      chk("ovf_inst", issue_inst, 64'h100 + 64'(i));
      chk("ovf_cyc", 64'(cyc - t0), 64'(21 + 2 * i));
    end
    tick();
    chk("ovf_drained", q_empty, 1);
    chk("ovf_no_late", late_err, 0);
    pulse_stop();

    // Wrap-around: labels 250 and 250+10 = 4 (mod 256)
    pulse_start();
    repeat (200) tick();
    push(64'hE1, 1, 0, 250);
    push(64'hE2, 1, 1, 10);
    wait_issue(300, got);
    chk("wrap_a_found", got, 1);
    chk("wrap_a_cyc", cyc - t0, 251);
    chk("wrap_a_time", issue_time, 250);
    wait_issue(300, got);
    chk("wrap_b_found", got, 1);
    chk("wrap_b_cyc", cyc - t0, 261);
    chk("wrap_b_time", issue_time, 4);
    chk("wrap_b_inst", issue_inst, 64'hE2);
    chk("wrap_late", late_err, 0);
    pulse_stop();

    // Late issue, then stop with queued far-future entries
    pulse_start();
    repeat (7) tick();
    push(64'hF0, 1, 0, 2);
    wait_issue(5, got);
    chk("late_found", got, 1);
    chk("late_cyc", cyc - t0, 9);
    chk("late_time", issue_time, 2);
    chk("late_flag", late_err, 1);
    push(64'hF1, 1, 0, 100);
    push(64'hF2, 0, 0, 0);
    push(64'hF3, 0, 0, 0);
    chk("stop_pre_empty", q_empty, 0);
    q_inst_valid = 1'b1;
    q_inst = 64'hF4;
    pulse_stop();
    q_inst_valid = 1'b0;
    chk("stop_empty", q_empty, 1);
    chk("stop_no_ovf", overflow_err, 0);
    chk("stop_no_issue", issue_valid, 0);
    wait_issue(20, got);
    chk("stop_quiet", got, 0);
    push(64'hF5, 1, 0, 0);
    pulse_start();
    wait_issue(5, got);
    chk("restart_found", got, 1);
    chk("restart_cyc", cyc - t0, 1);
    chk("restart_inst", issue_inst, 64'hF5);
    chk("restart_late", late_err, 0);

    // Async reset mid-run with 4 queued entries
    push(64'hD0, 1, 0, 0);
    wait_issue(5, got);
    chk("pre_rst_late", late_err, 1);
    for (int i = 0; i < 4; i++) push(64'hD1 + 64'(i), 1, 0, 100);
    chk("pre_rst_busy", q_empty, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b1;
    push(64'h77, 1, 0, 3);
    chk("post_rst_push", q_empty, 0);
    pulse_start();
    wait_issue(10, got);
    chk("post_rst_found", got, 1);
    chk("post_rst_cyc", cyc - t0, 4);
    chk("post_rst_inst", issue_inst, 64'h77);
    chk("post_rst_time", issue_time, 3);
    chk("post_rst_empty", q_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
